// File: rtl/mult_share_sequencer.sv
// Two-requester front end for the shared 4x4 multiplier / shifter / accumulator:
// round-robin grant, four partial-product steps, then a valid/ready result.
module mult_share_sequencer #(
   parameter int FIRST_PRIO = 0,
   parameter int SKIP_ZERO  = 1
) (
   input  logic        clk,
   input  logic        reset_a,
   input  logic        req_valid0,
   input  logic [7:0]  a0,
   input  logic [7:0]  b0,
   output logic        req_ready0,
   input  logic        req_valid1,
   input  logic [7:0]  a1,
   input  logic [7:0]  b1,
   output logic        req_ready1,
   output logic [7:0]  mul_dataa,
   output logic [7:0]  mul_datab,
   output logic [1:0]  mul_input_sel,
   output logic [1:0]  mul_shift_sel,
   output logic        mul_clk_ena,
   output logic        mul_sclr_n,
   input  logic [15:0] mul_product,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_id,
   output logic        busy,
   output logic [2:0]  state_out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0, CLR = 3'd1, ACC0 = 3'd2, ACC1 = 3'd3,
      ACC2 = 3'd4, ACC3 = 3'd5, DONE = 3'd6, RSP = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  dataa_q, dataa_d, datab_q, datab_d;
   logic        gid_q, gid_d, last_q, last_d, rsp_id_q, rsp_id_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        gnt_vld, gnt_id, skip;

   // On a tie the requester that did not win last time goes first.
   assign gnt_vld = req_valid0 | req_valid1;
   assign gnt_id  = (req_valid0 & req_valid1) ? ~last_q : req_valid1;
   assign skip    = (SKIP_ZERO != 0) && ((dataa_q == 8'h00) || (datab_q == 8'h00));

   always_comb begin
      state_d       = state_q;
      dataa_d       = dataa_q;
      datab_d       = datab_q;
      gid_d         = gid_q;
      last_d        = last_q;
      rsp_data_d    = rsp_data_q;
      rsp_id_d      = rsp_id_q;
      req_ready0    = 1'b0;
      req_ready1    = 1'b0;
      mul_clk_ena   = 1'b0;
      mul_sclr_n    = 1'b1;
      mul_input_sel = 2'b00;
      mul_shift_sel = 2'b00;
      rsp_valid     = 1'b0;
      case (state_q)
         IDLE: if (gnt_vld) begin
            req_ready0 = ~gnt_id;
            req_ready1 = gnt_id;
            dataa_d    = gnt_id ? a1 : a0;
            datab_d    = gnt_id ? b1 : b0;
            gid_d      = gnt_id;
            last_d     = gnt_id;
            state_d    = CLR;
         end
         CLR: begin
            mul_sclr_n  = 1'b0;
            mul_clk_ena = 1'b1;
            state_d     = skip ? DONE : ACC0;
         end
         ACC0: begin
            mul_clk_ena = 1'b1;
            state_d     = ACC1;
         end
         ACC1: begin
            mul_clk_ena   = 1'b1;
            mul_input_sel = 2'b01;
            mul_shift_sel = 2'b01;
            state_d       = ACC2;
         end
         ACC2: begin
            mul_clk_ena   = 1'b1;
            mul_input_sel = 2'b10;
            mul_shift_sel = 2'b01;
            state_d       = ACC3;
         end
         ACC3: begin
            mul_clk_ena   = 1'b1;
            mul_input_sel = 2'b11;
            mul_shift_sel = 2'b10;
            state_d       = DONE;
         end
         DONE: begin
            rsp_data_d = skip ? 16'h0000 : mul_product;
            rsp_id_d   = gid_q;
            state_d    = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         state_q    <= IDLE;
         dataa_q    <= 8'h00;
         datab_q    <= 8'h00;
         gid_q      <= 1'b0;
         last_q     <= (FIRST_PRIO == 0);
         rsp_data_q <= 16'h0000;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dataa_q    <= dataa_d;
         datab_q    <= datab_d;
         gid_q      <= gid_d;
         last_q     <= last_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign mul_dataa = dataa_q;
   assign mul_datab = datab_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);
   assign state_out = state_q;

endmodule

// File: tb/tb_mult_share_sequencer.sv
// Directed bench for mult_share_sequencer with a behavioural model of the
// shared 4x4 multiplier / shifter / accumulator hanging off its datapath port.
module tb_mult_share_sequencer;

   logic        clk, reset_a;
   logic        req_valid0, req_ready0, req_valid1, req_ready1;
   logic [7:0]  a0, b0, a1, b1, mul_dataa, mul_datab;
   logic [1:0]  mul_input_sel, mul_shift_sel;
   logic        mul_clk_ena, mul_sclr_n;
   logic [15:0] mul_product, rsp_data;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [2:0]  state_out;

   int n_chk = 0;
   int n_err = 0;

   mult_share_sequencer #(.FIRST_PRIO(0), .SKIP_ZERO(1)) dut (
      .clk(clk), .reset_a(reset_a),
      .req_valid0(req_valid0), .a0(a0), .b0(b0), .req_ready0(req_ready0),
      .req_valid1(req_valid1), .a1(a1), .b1(b1), .req_ready1(req_ready1),
      .mul_dataa(mul_dataa), .mul_datab(mul_datab),
      .mul_input_sel(mul_input_sel), .mul_shift_sel(mul_shift_sel),
      .mul_clk_ena(mul_clk_ena), .mul_sclr_n(mul_sclr_n), .mul_product(mul_product),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .busy(busy), .state_out(state_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Datapath model: nibble multiply, shift, accumulate with sync clear.
   logic [3:0]  na, nb;
   logic [15:0] pp, acc;
   always_comb begin
      na = mul_input_sel[1] ? mul_dataa[7:4] : mul_dataa[3:0];
      nb = mul_input_sel[0] ? mul_datab[7:4] : mul_datab[3:0];
      pp = {8'h00, 4'h0, na} * {8'h00, 4'h0, nb};
      if (mul_shift_sel == 2'b01)      pp = pp << 4;
      else if (mul_shift_sel == 2'b10) pp = pp << 8;
   end
   always @(posedge clk) begin
      if (mul_clk_ena) acc <= mul_sclr_n ? acc + pp : 16'h0000;
   end
   assign mul_product = acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string name);
      check(name, {18'h0, mul_dataa, mul_datab, rsp_data, rsp_id, rsp_valid, req_ready0,
                   req_ready1, busy, mul_clk_ena, mul_sclr_n, mul_input_sel, mul_shift_sel,
                   state_out},
                  {18'h0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0});
   endtask

   // Called at the drive point of T1; returns at the sample point of the first rsp_valid cycle.
   task automatic wait_rsp(output int cyc, output int n_ena, output logic [15:0] seq);
      cyc = 1; n_ena = 0; seq = 16'h0000;
      #1;
      while (!rsp_valid && cyc < 20) begin
         if (mul_clk_ena) n_ena++;
         if (mul_clk_ena && mul_sclr_n) seq = {seq[11:0], mul_input_sel, mul_shift_sel};
         @(posedge clk); #2;
         cyc++;
      end
   endtask

   task automatic do_reset();
      reset_a = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; rsp_ready = 1'b1;
      a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
      repeat (2) @(posedge clk);
      #1 chk_reset("reset_values");
      reset_a = 1'b1;
   endtask

   typedef struct {
      int          r;
      logic [7:0]  a, b;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[7];

   task automatic run_txn(input vec_t v);
      int cyc, n_ena;
      logic [15:0] seq;
      if (v.r == 0) begin req_valid0 = 1'b1; a0 = v.a; b0 = v.b; end
      else          begin req_valid1 = 1'b1; a1 = v.a; b1 = v.b; end
      #1 check("grant_ready", {62'h0, req_ready1, req_ready0}, (v.r == 0) ? 64'd1 : 64'd2);
      @(posedge clk); #1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      a0 = 8'hEE; b0 = 8'hEE; a1 = 8'hEE; b1 = 8'hEE;
      wait_rsp(cyc, n_ena, seq);
      check("latency", 64'(cyc), 64'(v.lat));
      check("rsp_data", {48'h0, rsp_data}, {48'h0, v.exp});
      check("rsp_id", {63'h0, rsp_id}, 64'(v.r));
      check("ena_cycles", 64'(n_ena), (v.lat == 7) ? 64'd5 : 64'd1);
      check("sel_shift_seq", {48'h0, seq}, (v.lat == 7) ? 64'h059E : 64'h0);
      check("rsp_state", {61'h0, state_out}, 64'd7);
      @(posedge clk); #1;
      check("back_idle", {62'h0, busy, rsp_valid}, 64'd0);
   endtask

   initial begin
      int cyc, n_ena, nbad;
      logic [15:0] seq;

      vt[0] = '{0, 8'hFF, 8'hFF, 16'hFE01, 7};
      vt[1] = '{1, 8'h9C, 8'h37, 16'h2184, 7};
      vt[2] = '{0, 8'h00, 8'h5A, 16'h0000, 3};
      vt[3] = '{1, 8'h12, 8'h00, 16'h0000, 3};
      vt[4] = '{1, 8'h01, 8'h01, 16'h0001, 7};
      vt[5] = '{0, 8'h80, 8'h02, 16'h0100, 7};
      vt[6] = '{1, 8'hAB, 8'hCD, 16'h88EF, 7};

      do_reset();
      for (int i = 0; i < 7; i++) run_txn(vt[i]);

      // Tie from reset: req0 wins; on the next tie req1 wins.
      do_reset();
      req_valid0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
      req_valid1 = 1'b1; a1 = 8'hAB; b1 = 8'hCD;
      #1 check("tie1_ready", {62'h0, req_ready1, req_ready0}, 64'd1);
      @(posedge clk); #1 req_valid0 = 1'b0;
      #1 check("busy_no_ready", {61'h0, busy, req_ready1, req_ready0}, 64'd4);
      #0; @(posedge clk); #1;
      wait_rsp(cyc, n_ena, seq);
      check("tie1_data", {47'h0, rsp_id, rsp_data}, {47'h0, 1'b0, 16'h03A8});
      @(posedge clk); #1;
      req_valid0 = 1'b1;
      #1 check("tie2_ready", {62'h0, req_ready1, req_ready0}, 64'd2);
      @(posedge clk); #1 req_valid1 = 1'b0;
      wait_rsp(cyc, n_ena, seq);
      check("tie2_data", {47'h0, rsp_id, rsp_data}, {47'h0, 1'b1, 16'h88EF});
      @(posedge clk); #1;
      #1 check("solo0_ready", {62'h0, req_ready1, req_ready0}, 64'd1);
      @(posedge clk); #1 req_valid0 = 1'b0;
      wait_rsp(cyc, n_ena, seq);
      check("solo0_data", {47'h0, rsp_id, rsp_data}, {47'h0, 1'b0, 16'h03A8});
      @(posedge clk); #1;

      // Backpressure: result held while req1 waits.
      rsp_ready = 1'b0;
      req_valid0 = 1'b1; a0 = 8'h03; b0 = 8'h05;
      @(posedge clk); #1 req_valid0 = 1'b0;
      wait_rsp(cyc, n_ena, seq);
      check("bp_latency", 64'(cyc), 64'd7);
      req_valid1 = 1'b1; a1 = 8'h02; b1 = 8'h03;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #2;
         check("bp_hold", {46'h0, rsp_valid, req_ready1, rsp_data},
                          {46'h0, 1'b1, 1'b0, 16'h000F});
      end
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      check("bp_regrant", {59'h0, state_out, req_ready1, req_ready0}, 64'd2);
      @(posedge clk); #1 req_valid1 = 1'b0;
      wait_rsp(cyc, n_ena, seq);
      check("bp_req1_data", {47'h0, rsp_id, rsp_data}, {47'h0, 1'b1, 16'h0006});
      @(posedge clk); #1;

      // Reset during ACC2 aborts immediately.
      req_valid0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
      @(posedge clk); #1 req_valid0 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #1 check("in_acc2", {61'h0, state_out}, 64'd4);
      reset_a = 1'b0;
      #1 chk_reset("async_abort");
      @(posedge clk); #1 reset_a = 1'b1;
      nbad = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #2;
         if (rsp_valid || busy) nbad++;
      end
      check("no_rsp_after_abort", 64'(nbad), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
